// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// oversample divider calculation used by both link directions.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; the clear input realigns the tick phase
// to a detected start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling with 3-sample majority vote, start glitch
// rejection, optional parity, framing/break handling and valid/ready output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);

    logic       sync1, sync2, sync3;
    logic [1:0] settle;
    logic       armed;
    rx_state_t  state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_acc, par_bad;
    logic       s7, s8;

    logic tick, start_edge, bit_val, sample_pt, bit_end, par_exp, deliver;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (start_edge),
        .tick  (tick)
    );

    // A low line at reset release must not look like an edge: only arm the
    // detector once the synchronised line has really been seen high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync3  <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            sync1  <= i_rxd;
            sync2  <= sync1;
            sync3  <= sync2;
            settle <= {settle[0], 1'b1};
            if (settle[1] && sync2) armed <= 1'b1;
        end
    end

    assign start_edge = (state == RX_IDLE) && armed && sync3 && !sync2;
    assign bit_val    = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign sample_pt  = tick && (tick_cnt == 4'd9);
    assign bit_end    = tick && (tick_cnt == 4'd15);
    assign par_exp    = (PARITY == PAR_ODD) ? ~par_acc : par_acc;
    assign deliver    = (state == RX_STOP) && sample_pt && bit_val && !par_bad;
    assign o_busy     = (state != RX_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            s7       <= 1'b0;
            s8       <= 1'b0;
        end else begin
            if (state != RX_IDLE && tick) begin
                tick_cnt <= tick_cnt + 1'b1;
                if (tick_cnt == 4'd7) s7 <= sync2;
                if (tick_cnt == 4'd8) s8 <= sync2;
            end
            case (state)
                RX_IDLE: begin
                    if (start_edge) begin
                        state    <= RX_START;
                        // The edge-detect cycle itself stands in for tick 0.
                        tick_cnt <= 4'd1;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        par_acc  <= 1'b0;
                        par_bad  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (sample_pt && bit_val) state <= RX_IDLE;
                    else if (bit_end)         state <= RX_DATA;
                end
                RX_DATA: begin
                    if (sample_pt) begin
                        shreg[bit_cnt] <= bit_val;
                        par_acc        <= par_acc ^ bit_val;
                    end
                    if (bit_end) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (sample_pt) par_bad <= (bit_val != par_exp);
                    if (bit_end)   state   <= RX_STOP;
                end
                RX_STOP: begin
                    if (sample_pt) state <= bit_val ? RX_IDLE : RX_BREAK;
                end
                RX_BREAK: begin
                    if (sync2) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err  <= (state == RX_STOP) && sample_pt && !bit_val;
            o_parity_err <= (state == RX_STOP) && sample_pt && bit_val && par_bad;
            o_overrun    <= deliver && o_valid && !i_ready;
            if (deliver && (!o_valid || i_ready)) begin
                o_data  <= shreg;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV = 1 (16 clocks per bit): an 8N1
// instance and an 8E1 instance, driven with frames built from byte values.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd0, rxd1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, busy0, busy1;
    logic       ferr0, ferr1, perr0, perr1, ovr0, ovr1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned t_start = 0;

    // Monotonic event counters written only by the monitor.
    int unsigned vh0 = 0, fe0 = 0, pe0 = 0, ov0 = 0, bh0 = 0, rise0 = 0;
    int unsigned fe1 = 0, pe1 = 0, ov1 = 0;
    logic        prev0 = 1'b0;
    logic [7:0]  got0[$];
    logic [7:0]  got1[$];

    int unsigned b_vh0, b_fe0, b_pe0, b_ov0, b_bh0, b_fe1, b_pe1, b_ov1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .DATA_BITS(8), .PARITY(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd0), .o_data(data0), .o_valid(valid0),
        .i_ready(ready0), .o_busy(busy0), .o_frame_err(ferr0), .o_parity_err(perr0),
        .o_overrun(ovr0)
    );

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD(3_125_000), .DATA_BITS(8), .PARITY(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd1), .o_data(data1), .o_valid(valid1),
        .i_ready(ready1), .o_busy(busy1), .o_frame_err(ferr1), .o_parity_err(perr1),
        .o_overrun(ovr1)
    );

    always @(negedge clk) begin
        if (valid0)           vh0 <= vh0 + 1;
        if (valid0 && !prev0) rise0 <= cyc;
        prev0 <= valid0;
        if (valid0 && ready0) got0.push_back(data0);
        if (valid1 && ready1) got1.push_back(data1);
        if (ferr0) fe0 <= fe0 + 1;
        if (perr0) pe0 <= pe0 + 1;
        if (ovr0)  ov0 <= ov0 + 1;
        if (busy0) bh0 <= bh0 + 1;
        if (ferr1) fe1 <= fe1 + 1;
        if (perr1) pe1 <= pe1 + 1;
        if (ovr1)  ov1 <= ov1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_vh0 = vh0; b_fe0 = fe0; b_pe0 = pe0; b_ov0 = ov0; b_bh0 = bh0;
        b_fe1 = fe1; b_pe1 = pe1; b_ov1 = ov1;
        got0.delete();
        got1.delete();
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Parity bit that makes the total count of ones even (mode 2) or odd (mode 1).
    function automatic logic par_bit(input logic [7:0] d, input int unsigned mode);
        logic even_bit;
        even_bit = 1'($countones(d) % 2);
        return (mode == 1) ? !even_bit : even_bit;
    endfunction

    task automatic drive(input int unsigned line, input logic v);
        if (line == 0) rxd0 = v;
        else           rxd1 = v;
    endtask

    task automatic send_frame(input int unsigned line, input logic [7:0] d,
                              input int unsigned mode, input logic par_flip,
                              input logic stop_val);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (mode != 0) b.push_back(par_bit(d, mode) ^ par_flip);
        b.push_back(stop_val);
        for (int i = 0; i < b.size(); i++) begin
            @(posedge clk);
            #1;
            drive(line, b[i]);
            if (i == 0) t_start = cyc;
            repeat (15) @(posedge clk);
        end
    endtask

    task automatic check_queue(input string tag, input logic [7:0] exp_q[$], input int unsigned line);
        int unsigned n;
        n = (line == 0) ? got0.size() : got1.size();
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check({tag, "_byte"}, 32'((line == 0) ? got0[i] : got1[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic       flip;
        int unsigned n_bad;

        rst_n = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data0",  32'(data0), 0);
        check("rst_valid0", 32'(valid0), 0);
        check("rst_busy",   32'({busy0, busy1}), 0);
        check("rst_flags",  32'({ferr0, perr0, ovr0, ferr1, perr1, ovr1}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(5);

        // Single 8N1 byte and its cycle-accurate latency.
        snap();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        idle(10);
        check("t1_latency", rise0 - t_start, 156);
        check("t1_valid_cycles", vh0 - b_vh0, 1);
        check("t1_flags", (fe0 - b_fe0) + (pe0 - b_pe0) + (ov0 - b_ov0), 0);
        exp_q = '{8'hA5};
        check_queue("t1", exp_q, 0);

        // Back-to-back frames: fixed corner bytes followed by random ones.
        snap();
        exp_q = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < exp_q.size(); i++) send_frame(0, exp_q[i], 0, 1'b0, 1'b1);
        idle(10);
        check_queue("t2", exp_q, 0);
        check("t2_frame_err", fe0 - b_fe0, 0);

        // Overrun: second byte dropped while the first is unconsumed.
        snap();
        ready0 = 1'b0;
        send_frame(0, 8'h12, 0, 1'b0, 1'b1);
        send_frame(0, 8'h34, 0, 1'b0, 1'b1);
        idle(10);
        check("t3_held_data", 32'(data0), 32'h12);
        check("t3_held_valid", 32'(valid0), 1);
        check("t3_overrun", ov0 - b_ov0, 1);
        ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_valid_fall", 32'(valid0), 0);
        exp_q = '{8'h12};
        check_queue("t3", exp_q, 0);

        // Framing error followed by a long break, then recovery.
        snap();
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        idle(500);
        rxd0 = 1'b1;
        idle(20);
        check("t4_frame_err", fe0 - b_fe0, 1);
        check("t4_no_valid", vh0 - b_vh0, 0);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1);
        idle(10);
        exp_q = '{8'h81};
        check_queue("t4", exp_q, 0);
        check("t4_frame_err_after", fe0 - b_fe0, 1);

        // Short low glitch on an idle line.
        snap();
        @(posedge clk); #1 rxd0 = 1'b0;
        t_start = cyc;
        repeat (5) @(posedge clk);
        #1 rxd0 = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("t5_glitch_cycle", cyc - t_start, 26);
        check("t5_glitch_busy", 32'(busy0), 0);
        check("t5_glitch_quiet", (vh0 - b_vh0) + (fe0 - b_fe0) + (pe0 - b_pe0), 0);

        // Even parity: 0x07 has three ones so a 0 parity bit is wrong.
        snap();
        send_frame(1, 8'h07, 2, 1'b1, 1'b1);
        idle(10);
        check("t5_parity_err", pe1 - b_pe1, 1);
        check("t5_parity_novalid", got1.size(), 0);

        // Random even-parity frames, some with a corrupted parity bit.
        snap();
        exp_q.delete();
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom_range(0, 255));
            flip = 1'($urandom_range(0, 1));
            if (flip) n_bad++;
            else      exp_q.push_back(d);
            send_frame(1, d, 2, flip, 1'b1);
        end
        idle(10);
        check_queue("t5_rand", exp_q, 1);
        check("t5_rand_perr", pe1 - b_pe1, n_bad);
        check("t5_rand_other", (fe1 - b_fe1) + (ov1 - b_ov1), 0);

        // Reset during data bit 3 of 0xC3 while the line is low.
        snap();
        fork
            send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
        join_none
        repeat (70) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_data", 32'(data0), 0);
        check("t6_rst_valid_busy", 32'({valid0, busy0}), 0);
        check("t6_rst_flags", 32'({ferr0, perr0, ovr0}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        b_bh0 = bh0;
        idle(100);
        check("t6_no_false_start", bh0 - b_bh0, 0);
        check("t6_no_delivery", got0.size(), 0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        idle(10);
        exp_q = '{8'h5A};
        check_queue("t6", exp_q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises an asynchronous serial line into bytes with 16x oversampling, majority-vote bit sampling, start-bit glitch rejection, optional parity checking, framing-error detection and overrun detection. It is the receiving end of the board's UART link and sits beside the UART transmitter in the top level. It decodes the `uart_txd` stream from a peer, or from the transmitter in loopback, and hands bytes to on-chip logic over a valid/ready interface.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: `i_clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DATA_BITS`, default 8: payload bits per frame. Legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.

Ports:
- `i_clk`, in, 1: system clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_rxd`, in, 1: serial line, asynchronous to `i_clk`, idles high.
- `o_data`, out, 8: received byte, LSB-aligned. Unused MSBs are 0.
- `o_valid`, out, 1: `o_data` holds an unconsumed byte.
- `i_ready`, in, 1: consumer accepts `o_data`.
- `o_busy`, out, 1: a frame is in progress (state is not IDLE).
- `o_frame_err`, out, 1: 1-cycle pulse when the stop bit is sampled low.
- `o_parity_err`, out, 1: 1-cycle pulse on a parity mismatch.
- `o_overrun`, out, 1: 1-cycle pulse when a good byte is dropped because `o_valid` is still pending.

## Operation
- **Input synchroniser.** `i_rxd` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Falling-edge detect.** Uses a third flop that also resets to 1.
- **Oversample tick.** Asserted every `DIV = (CLK_FREQ + 8*BAUD) / (16*BAUD)` cycles, which is round-to-nearest. DIV must be at least 1.
- **Tick counter.** A 4-bit counter counts ticks within each bit. It restarts at 0 on the start edge.
- **Bit value.** The majority of the synchronised samples taken at ticks 7, 8 and 9. The decision is made on the tick-9 cycle.
- **State machine (`rx_state_t`):**
  - IDLE: falling edge → START, and the tick divider is cleared.
  - START: bit value 1 → IDLE (glitch rejected, no flags). Bit value 0 → DATA at the end of the bit (tick 15).
  - DATA: shift in `DATA_BITS` bits, LSB first. Then go to PARITY if `PARITY != 0`, otherwise to STOP.
  - PARITY: compare the received bit against the XOR of the data bits, inverted for odd parity. Record any mismatch, then → STOP.
  - STOP, bit value 1 with no parity mismatch: deliver the byte, → IDLE immediately on the tick-9 cycle, so back-to-back frames are not lost.
  - STOP, bit value 1 with a parity mismatch: pulse `o_parity_err`, discard the byte, → IDLE.
  - STOP, bit value 0: pulse `o_frame_err`, discard the byte, → BREAK.
  - BREAK: wait for the synchronised line to be 1, then → IDLE. A held-low line (break) produces exactly one `o_frame_err`.
- **Delivery rules:**
  - `o_valid` = 0: load `o_data` and set `o_valid`.
  - `o_valid` = 1 and `i_ready` = 1 in the same cycle: the old byte is consumed, the new byte is loaded, and `o_valid` stays 1.
  - `o_valid` = 1 and `i_ready` = 0: keep the old byte, drop the new one, pulse `o_overrun`.
- **Handshake.** A transfer occurs on any cycle with `o_valid && i_ready`. `o_valid` falls the next cycle unless a new byte is loaded in that same cycle. `o_data` is stable while `o_valid` is high.
- **Reset.** Reset at any time returns the state to IDLE and clears all outputs to 0; `o_data` also clears to 0. A line that is already low at reset release is not treated as a start bit. Only a new 1→0 transition starts a frame.

## Timing
- Each output pulse is exactly 1 cycle wide and registered.
- Latency from the line falling edge to `o_valid` is 2 cycles of synchroniser delay, plus `(1 + DATA_BITS + P)*16 + 9` ticks, plus 1 cycle for the output register. P is 1 if parity is enabled and 0 otherwise.
- With `DIV` = 1, 8N1: `o_valid` rises 156 cycles after the falling edge of `i_rxd`. This is the cycle-accurate reference figure.
- Tolerated baud mismatch is at least ±3% between sender and receiver.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity encodings `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the `uart_div()` function.
- The package is shared with the future transmitter.
- One sub-module, `uart_baud_tick`, generates the oversample tick. It has a synchronous clear input, driven by the start-edge detect.

## Test plan
All scenarios use `CLK_FREQ` = 50_000_000 and `BAUD` = 3_125_000, so `DIV` = 1 and one bit is 16 cycles.
1. **Single 8N1 byte.** Send 0xA5 with `i_ready` = 1 → `o_valid` pulses for 1 cycle with `o_data` = 0xA5, 156 cycles after the start edge. No error flags.
2. **Back-to-back frames.** Send 0x00, 0xFF, 0x55 with no idle gap and `i_ready` = 1 → three deliveries in order, all correct.
3. **Overrun.** Hold `i_ready` = 0 and send 0x12 then 0x34 → `o_data` stays 0x12 and `o_overrun` pulses once. Then `i_ready` = 1 → 0x12 is consumed and `o_valid` falls.
4. **Framing error and break.** Send 0x3C with the stop bit forced low, then hold the line low for 500 cycles → exactly one `o_frame_err` pulse and no `o_valid`. Release the line and send 0x81 → 0x81 is received.
5. **Glitch and parity.** Apply a 5-cycle low glitch on an idle line → no activity, and `o_busy` returns to 0 by cycle 26. With `PARITY` = 2, send 0x07 with parity bit 0 → `o_parity_err` pulses and no `o_valid`.
6. **Reset mid-frame.** Assert `i_rst_n` low during data bit 3 of 0xC3 while the line is low → all outputs are 0. A fresh 0x5A sent after release is received correctly.
